// File: rtl/factorial_pkg.sv
// Shared types and default widths for the factorial engine.
package factorial_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_IN_DATA_WD  = 4;
    localparam int DEF_OUT_DATA_WD = 46;
endpackage

// File: rtl/factorial_if.sv
// Operand/result handshake bundle; master drives operands, slave is the engine.
interface factorial_if #(
    parameter int IN_DATA_WD  = 4,
    parameter int OUT_DATA_WD = 46
);
    logic [IN_DATA_WD-1:0]  in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [OUT_DATA_WD-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_busy;
    logic                   out_ovf;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_busy, out_ovf
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_busy, out_ovf
    );
endinterface

// File: rtl/factorial_mul.sv
// acc*cnt at full width; o_ovf flags any product bit above OUT_DATA_WD.
module factorial_mul
    import factorial_pkg::*;
#(
    parameter int IN_DATA_WD  = DEF_IN_DATA_WD,
    parameter int OUT_DATA_WD = DEF_OUT_DATA_WD
) (
    input  logic [OUT_DATA_WD-1:0] i_acc,
    input  logic [IN_DATA_WD-1:0]  i_cnt,
    output logic [OUT_DATA_WD-1:0] o_prod,
    output logic                   o_ovf
);
    logic [OUT_DATA_WD+IN_DATA_WD-1:0] w_full;

    assign w_full = {{IN_DATA_WD{1'b0}}, i_acc} * {{OUT_DATA_WD{1'b0}}, i_cnt};
    assign o_prod = w_full[OUT_DATA_WD-1:0];
    assign o_ovf  = |w_full[OUT_DATA_WD+IN_DATA_WD-1:OUT_DATA_WD];
endmodule

// File: rtl/factorial_engine.sv
// Iterative n! engine with valid/ready handshakes on both sides.
// Define FACTORIAL_OVF_SAT_EN to saturate out_data and report out_ovf on overflow.
module factorial_engine
    import factorial_pkg::*;
#(
    parameter int IN_DATA_WD  = DEF_IN_DATA_WD,
    parameter int OUT_DATA_WD = DEF_OUT_DATA_WD
) (
    input  logic       clk,
    input  logic       resetn,
    factorial_if.slave bus
);
`ifdef FACTORIAL_OVF_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [OUT_DATA_WD-1:0] r_out_data;
    logic                   r_out_ovf;
    logic                   r_busy;
    logic [OUT_DATA_WD-1:0] r_acc;
    logic [IN_DATA_WD-1:0]  r_cnt;
    logic                   r_ovf;

    logic [OUT_DATA_WD-1:0] w_prod;
    logic                   w_ovf;

    factorial_mul #(
        .IN_DATA_WD (IN_DATA_WD),
        .OUT_DATA_WD(OUT_DATA_WD)
    ) u_mul (
        .i_acc (r_acc),
        .i_cnt (r_cnt),
        .o_prod(w_prod),
        .o_ovf (w_ovf)
    );

    // DONE spends its first cycle loading the output registers, so a result is
    // only handed off once out_valid is already visible to the consumer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_busy      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_acc      <= OUT_DATA_WD'(1);
                        r_cnt      <= bus.in_data;
                        r_ovf      <= 1'b0;
                        r_state    <= CALC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                CALC: begin
                    if (r_cnt <= IN_DATA_WD'(1)) begin
                        r_state <= DONE;
                    end else begin
                        r_acc <= w_prod;
                        r_cnt <= r_cnt - IN_DATA_WD'(1);
                        r_ovf <= r_ovf | w_ovf;
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= (SAT_EN && r_ovf) ? '1 : r_acc;
                        r_out_ovf   <= SAT_EN && r_ovf;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_busy  = r_busy;
endmodule

// File: doc/factorial_engine.md
FACTORIAL_ENGINE -- requirements
Module: factorial_engine

Interface
REQ-001 Parameter IN_DATA_WD, default 4, SHALL set the operand n width.
REQ-002 Parameter OUT_DATA_WD, default 46, SHALL set the result width; legal range 8..64.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port in_data  input  IN_DATA_WD  SHALL carry operand n (unsigned).
REQ-006 Port in_valid  input  1  SHALL mark in_data valid.
REQ-007 Port in_ready  output  1  SHALL indicate the engine accepts an operand this cycle.
REQ-008 Port out_data  output  OUT_DATA_WD  SHALL carry n! (unsigned).
REQ-009 Port out_valid  output  1  SHALL mark out_data valid.
REQ-010 Port out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-011 Port out_busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 Port out_ovf  output  1  SHALL flag that the true n! exceeded OUT_DATA_WD bits; qualified by out_valid.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 in_ready SHALL equal (state == IDLE), driven from a register; there is no combinational path from in_valid to in_ready.
REQ-015 Accept SHALL occur when in_valid && in_ready; then acc <= 1, cnt <= in_data, ovf <= 0, state -> CALC.
REQ-016 In CALC with cnt <= 1, state SHALL go to DONE; otherwise acc <= acc*cnt and cnt <= cnt-1.
REQ-017 For an accept at edge T, out_valid SHALL first be high after edge T + max(n,1) + 1.
REQ-018 n=0 and n=1 SHALL both yield out_data = 1, out_ovf = 0, with latency 2.
REQ-019 Multiplication SHALL be evaluated at OUT_DATA_WD+IN_DATA_WD bits; ovf SHALL be sticky per job once any upper bit is nonzero.
REQ-020 In DONE, out_valid SHALL be high and out_data/out_ovf SHALL hold stable until out_ready is sampled high; then state -> IDLE.
REQ-021 in_valid SHALL be ignored while not IDLE; an operand is never lost or merged, because none is accepted outside IDLE.
REQ-022 out_ready while not in DONE SHALL have no effect.

Reset
REQ-023 While resetn is low: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_ovf = 0, out_busy = 0, acc = 0, cnt = 0.
REQ-024 Reset asserted mid-CALC or mid-DONE SHALL abort the job immediately; no result is produced after release.

Configuration
REQ-025 Macro FACTORIAL_OVF_SAT_EN defined: overflow SHALL set out_ovf = 1 and force out_data to all-ones.
REQ-026 Macro FACTORIAL_OVF_SAT_EN undefined: out_ovf SHALL be tied 0 and out_data SHALL equal n! mod 2^OUT_DATA_WD.

Structure
REQ-027 Package factorial_pkg SHALL hold the state enum (IDLE/CALC/DONE) and default width localparams.
REQ-028 Sub-module factorial_mul SHALL implement the width-parametrised acc*cnt product with an upper-bits-nonzero flag; the FSM lives in factorial_engine.

Verification
REQ-029 Directed scenarios the bench SHALL cover:
- Reset then n=5 accepted at edge T, out_ready=1 -> out_valid after edge T+6, out_data=120, out_ovf=0, out_busy low the cycle after the handshake.
- n=0, then n=1 back-to-back -> each result = 1 with latency 2; in_ready low between accept and result handshake.
- n=15, defaults -> out_data=1307674368000 after edge T+16, out_ovf=0.
- OUT_DATA_WD=16, n=9 -> with FACTORIAL_OVF_SAT_EN: out_data=0xFFFF, out_ovf=1; without: out_data=0x8980, out_ovf=0.
- n=4 with out_ready held low 10 cycles, in_valid held high with n=7 -> out_data=24 stable throughout; n=7 accepted only after the handshake, then yields 5040.
- resetn pulsed low mid-CALC for n=10 -> all outputs at reset values, in_ready=1 after release, no out_valid until a new accept.
